// File: rtl/mli_pkg.sv
// Shared types and constants for the memory latency injector with DRAM contention model.
package mli_pkg;

   localparam int unsigned CNT_W        = 32;
   localparam int unsigned ENTRY_SIZE_W = 32;
   localparam int unsigned LAT_W        = 16;
   localparam int unsigned LFSR_W       = 16;

   localparam logic [LFSR_W-1:0] LFSR_POLY = 16'hB400;
   localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;

   typedef struct packed {
      logic [ENTRY_SIZE_W-1:0] size;
      logic                    is_dram;
      logic [LAT_W-1:0]        countdown;
      logic                    blocked;
   } mli_entry_t;

   // Galois right-shift step of the 16-bit LFSR
   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
      return {1'b0, s[LFSR_W-1:1]} ^ (s[0] ? LFSR_POLY : '0);
   endfunction

endpackage

// File: rtl/dram_token_bucket.sv
// Token-bucket bandwidth limiter gating DRAM response completion.
module dram_token_bucket
   import mli_pkg::*;
#(
   parameter int unsigned DEFAULT_RATE     = 4,
   parameter int unsigned DEFAULT_CAPACITY = 32,
   parameter int unsigned COST_SHIFT       = 3
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic [7:0]              cfg_rate,
   input  logic [15:0]             cfg_capacity,
   input  logic                    request,
   input  logic [ENTRY_SIZE_W-1:0] size_bytes,
   output logic                    grant_c,
   output logic [15:0]             tokens
);

   logic [15:0]             cap_c;
   logic [7:0]              rate_c;
   logic [ENTRY_SIZE_W-1:0] raw_cost_c;
   logic [15:0]             cost_c;
   logic [16:0]             sum_c;
   logic [15:0]             tokens_nxt_c;

   // Effective config, clamped cost, and saturating refill
   always_comb begin
      cap_c      = (cfg_capacity == '0) ? 16'(DEFAULT_CAPACITY) : cfg_capacity;
      rate_c     = (cfg_rate == '0) ? 8'(DEFAULT_RATE) : cfg_rate;
      raw_cost_c = size_bytes >> COST_SHIFT;
      if (raw_cost_c == '0)
         cost_c = 16'd1;
      else if (raw_cost_c > ENTRY_SIZE_W'(cap_c))
         cost_c = cap_c;
      else
         cost_c = 16'(raw_cost_c);
      grant_c = !enable || (tokens >= cost_c);
      sum_c   = 17'(tokens) + 17'(rate_c);
      if (enable && request && grant_c)
         sum_c = sum_c - 17'(cost_c);
      tokens_nxt_c = (sum_c > 17'(cap_c)) ? cap_c : sum_c[15:0];
   end

   always_ff @(posedge clk) begin
      if (reset || !enable)
         tokens <= cap_c;
      else
         tokens <= tokens_nxt_c;
   end

endmodule

// File: rtl/memory_latency_injector_contention.sv
// Memory-timing model: in-order latency FIFO with per-class latency and DRAM token throttling.
module memory_latency_injector_contention
   import mli_pkg::*;
#(
   parameter int unsigned SIZE_WIDTH            = 16,
   parameter int unsigned LATENCY_SRAM_CYCLES   = 2,
   parameter int unsigned LATENCY_DRAM_CYCLES   = 10,
   parameter int unsigned PIPELINE_RESP         = 0,
   parameter int unsigned QUEUE_DEPTH           = 4,
   parameter int unsigned EXTRA_LATENCY_MAX     = 0,
   parameter int unsigned LATENCY_DIST_MODE     = 0,
   parameter int unsigned DRAM_TOKENS_PER_CYCLE = 4,
   parameter int unsigned DRAM_TOKEN_CAPACITY   = 32,
   parameter int unsigned SIZE_TO_TOKENS_SHIFT  = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   input  logic                  req_is_dram,
   input  logic [SIZE_WIDTH-1:0] req_size_bytes,
   output logic                  req_ready,
   output logic                  resp_valid,
   output logic [SIZE_WIDTH-1:0] resp_size_bytes,
   input  logic [15:0]           cfg_latency_sram,
   input  logic [15:0]           cfg_latency_dram,
   input  logic [9:0]            cfg_dram_hit_milli_pct,
   input  logic                  cfg_use_cfg_latencies,
   input  logic                  cfg_enable_contention,
   input  logic [7:0]            cfg_tokens_per_cycle,
   input  logic [15:0]           cfg_token_capacity,
   output logic [CNT_W-1:0]      total_reqs,
   output logic [CNT_W-1:0]      total_resp,
   output logic [CNT_W-1:0]      sram_reqs,
   output logic [CNT_W-1:0]      dram_reqs,
   output logic [CNT_W-1:0]      stall_cycles,
   output logic [CNT_W-1:0]      busy_cycles,
   output logic                  busy,
   output logic [15:0]           dram_tokens_level,
   output logic [CNT_W-1:0]      dram_token_stall_cycles,
   output logic [CNT_W-1:0]      dram_contention_events
);

   localparam int unsigned      PTR_W    = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam int unsigned      OCC_W    = $clog2(QUEUE_DEPTH + 1);
   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(QUEUE_DEPTH);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(QUEUE_DEPTH - 1);

   mli_entry_t        fifo [QUEUE_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [OCC_W-1:0]  count;
   logic [LFSR_W-1:0] lfsr;
   logic              pop_q;
   logic [SIZE_WIDTH-1:0] pop_size_q;

   mli_entry_t        head_c;
   logic              head_expired_c;
   logic              grant_c;
   logic              pop_c;
   logic              blocked_c;
   logic              accept_c;
   logic              reclass_c;
   logic              is_dram_c;
   logic [LAT_W-1:0]  base_c;
   logic [LAT_W-1:0]  extra_c;
   logic [LAT_W:0]    lat_sum_c;
   logic [LAT_W-1:0]  lat_c;
   logic [OCC_W-1:0]  count_nxt_c;

   // Head completion, classification and latency of the incoming request
   always_comb begin
      head_c         = fifo[rd_ptr];
      head_expired_c = (count != '0) && (head_c.countdown <= LAT_W'(1));
      pop_c          = head_expired_c && (!head_c.is_dram || grant_c);
      blocked_c      = head_expired_c && head_c.is_dram && !grant_c;
      accept_c       = req_valid && req_ready;
      reclass_c      = !req_is_dram && (cfg_dram_hit_milli_pct != '0) &&
                       ((lfsr % 16'd1000) < 16'(cfg_dram_hit_milli_pct));
      is_dram_c      = req_is_dram || reclass_c;
      if (cfg_use_cfg_latencies)
         base_c = is_dram_c ? cfg_latency_dram : cfg_latency_sram;
      else
         base_c = is_dram_c ? LAT_W'(LATENCY_DRAM_CYCLES) : LAT_W'(LATENCY_SRAM_CYCLES);
      if (LATENCY_DIST_MODE == 1)
         extra_c = LAT_W'(EXTRA_LATENCY_MAX);
      else
         extra_c = LAT_W'(32'(lfsr) % (EXTRA_LATENCY_MAX + 1));
      lat_sum_c = (LAT_W+1)'(base_c) + (LAT_W+1)'(extra_c);
      if (lat_sum_c == '0)
         lat_c = LAT_W'(1);
      else if (lat_sum_c[LAT_W])
         lat_c = '1;
      else
         lat_c = lat_sum_c[LAT_W-1:0];
      count_nxt_c = count + OCC_W'(accept_c) - OCC_W'(pop_c);
   end

   dram_token_bucket #(
      .DEFAULT_RATE     (DRAM_TOKENS_PER_CYCLE),
      .DEFAULT_CAPACITY (DRAM_TOKEN_CAPACITY),
      .COST_SHIFT       (SIZE_TO_TOKENS_SHIFT)
   ) u_bucket (
      .clk          (clk),
      .reset        (reset),
      .enable       (cfg_enable_contention),
      .cfg_rate     (cfg_tokens_per_cycle),
      .cfg_capacity (cfg_token_capacity),
      .request      (head_expired_c && head_c.is_dram),
      .size_bytes   (head_c.size),
      .grant_c      (grant_c),
      .tokens       (dram_tokens_level)
   );

   // Queue storage, pointers and countdowns
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < QUEUE_DEPTH; i++)
            fifo[i] <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         req_ready <= 1'b1;
         busy      <= 1'b0;
         lfsr      <= LFSR_SEED;
      end else begin
         for (int i = 0; i < QUEUE_DEPTH; i++)
            if (fifo[i].countdown != '0)
               fifo[i].countdown <= fifo[i].countdown - LAT_W'(1);
         if (blocked_c)
            fifo[rd_ptr].blocked <= 1'b1;
         if (accept_c) begin
            fifo[wr_ptr] <= '{size:      ENTRY_SIZE_W'(req_size_bytes),
                              is_dram:   is_dram_c,
                              countdown: lat_c,
                              blocked:   1'b0};
            wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
         end
         if (pop_c)
            rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
         count     <= count_nxt_c;
         req_ready <= (count_nxt_c != OCC_FULL);
         busy      <= (count_nxt_c != '0);
         lfsr      <= lfsr_step(lfsr);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pop_q      <= 1'b0;
         pop_size_q <= '0;
      end else begin
         pop_q      <= pop_c;
         pop_size_q <= SIZE_WIDTH'(head_c.size);
      end
   end

   // Optional extra output stage
   generate
      if (PIPELINE_RESP != 0) begin : g_pipe
         always_ff @(posedge clk) begin
            if (reset) begin
               resp_valid      <= 1'b0;
               resp_size_bytes <= '0;
            end else begin
               resp_valid      <= pop_q;
               resp_size_bytes <= pop_size_q;
            end
         end
      end else begin : g_nopipe
         assign resp_valid      = pop_q;
         assign resp_size_bytes = pop_size_q;
      end
   endgenerate

   // Performance counters
   always_ff @(posedge clk) begin
      if (reset) begin
         total_reqs              <= '0;
         total_resp              <= '0;
         sram_reqs               <= '0;
         dram_reqs               <= '0;
         stall_cycles            <= '0;
         busy_cycles             <= '0;
         dram_token_stall_cycles <= '0;
         dram_contention_events  <= '0;
      end else begin
         if (accept_c)                         total_reqs <= total_reqs + 32'd1;
         if (accept_c && !is_dram_c)           sram_reqs <= sram_reqs + 32'd1;
         if (accept_c && is_dram_c)            dram_reqs <= dram_reqs + 32'd1;
         if (resp_valid)                       total_resp <= total_resp + 32'd1;
         if (req_valid && !req_ready)          stall_cycles <= stall_cycles + 32'd1;
         if (busy)                             busy_cycles <= busy_cycles + 32'd1;
         if (blocked_c)                        dram_token_stall_cycles <= dram_token_stall_cycles + 32'd1;
         if (blocked_c && !head_c.blocked)     dram_contention_events <= dram_contention_events + 32'd1;
      end
   end

endmodule

// File: tb/tb_memory_latency_injector_contention.sv
// Self-checking bench: single-request vector table plus multi-cycle contention/backpressure/reset sequences.
module tb_memory_latency_injector_contention;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_is_dram, req_ready, resp_valid, busy;
   logic [15:0] req_size_bytes, resp_size_bytes;
   logic [15:0] cfg_latency_sram, cfg_latency_dram, cfg_token_capacity, dram_tokens_level;
   logic [9:0]  cfg_dram_hit_milli_pct;
   logic        cfg_use_cfg_latencies, cfg_enable_contention;
   logic [7:0]  cfg_tokens_per_cycle;
   logic [31:0] total_reqs, total_resp, sram_reqs, dram_reqs, stall_cycles, busy_cycles;
   logic [31:0] dram_token_stall_cycles, dram_contention_events;

   memory_latency_injector_contention dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_is_dram(req_is_dram),
      .req_size_bytes(req_size_bytes), .req_ready(req_ready), .resp_valid(resp_valid),
      .resp_size_bytes(resp_size_bytes), .cfg_latency_sram(cfg_latency_sram),
      .cfg_latency_dram(cfg_latency_dram), .cfg_dram_hit_milli_pct(cfg_dram_hit_milli_pct),
      .cfg_use_cfg_latencies(cfg_use_cfg_latencies), .cfg_enable_contention(cfg_enable_contention),
      .cfg_tokens_per_cycle(cfg_tokens_per_cycle), .cfg_token_capacity(cfg_token_capacity),
      .total_reqs(total_reqs), .total_resp(total_resp), .sram_reqs(sram_reqs), .dram_reqs(dram_reqs),
      .stall_cycles(stall_cycles), .busy_cycles(busy_cycles), .busy(busy),
      .dram_tokens_level(dram_tokens_level), .dram_token_stall_cycles(dram_token_stall_cycles),
      .dram_contention_events(dram_contention_events)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] size;
      int          acc_cyc;
      int          exp_lat;
   } sb_t;

   typedef struct {
      logic        use_cfg;
      logic        is_dram;
      logic [15:0] size;
      logic [15:0] lat_sram;
      logic [15:0] lat_dram;
      logic [9:0]  pct;
      int          exp_lat;
      logic        exp_dram;
   } vec_t;

   sb_t         sb_q[$];
   vec_t        vecs[8];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          cur_exp_lat = 0;
   int          resp_seen = 0;
   logic [15:0] max_tok = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard: push on accept, pop and compare on response
   always @(negedge clk) begin
      if (!reset) begin
         if (dram_tokens_level > max_tok) max_tok = dram_tokens_level;
         if (req_valid && req_ready)
            sb_q.push_back('{size: req_size_bytes, acc_cyc: cyc + 1, exp_lat: cur_exp_lat});
         if (resp_valid) begin
            sb_t e;
            resp_seen++;
            if (sb_q.size() == 0) begin
               check("unexpected_resp", 32'd1, 32'd0);
            end else begin
               e = sb_q.pop_front();
               check("resp_size", 32'(resp_size_bytes), 32'(e.size));
               if (e.exp_lat != 0)
                  check("resp_latency", 32'(cyc - e.acc_cyc), 32'(e.exp_lat));
            end
         end
      end
   end

   task automatic set_cfg(input logic use_cfg, input logic [15:0] ls, input logic [15:0] ld,
                          input logic [9:0] pct, input logic en, input logic [7:0] rate,
                          input logic [15:0] cap);
      cfg_use_cfg_latencies  = use_cfg;
      cfg_latency_sram       = ls;
      cfg_latency_dram       = ld;
      cfg_dram_hit_milli_pct = pct;
      cfg_enable_contention  = en;
      cfg_tokens_per_cycle   = rate;
      cfg_token_capacity     = cap;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      req_valid = 1'b0;
      sb_q.delete();
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      max_tok   = '0;
      resp_seen = 0;
   endtask

   // Holds the request until accepted; returns at posedge+1 with req_valid still high
   task automatic send(input logic is_dram, input logic [15:0] size);
      bit ok = 0;
      req_valid      = 1'b1;
      req_is_dram    = is_dram;
      req_size_bytes = size;
      for (int i = 0; i < 500 && !ok; i++) begin
         @(negedge clk);
         if (req_ready) ok = 1;
      end
      if (!ok) check("send_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain();
      bit done = 0;
      for (int i = 0; i < 1000 && !done; i++) begin
         @(negedge clk);
         if (!busy && sb_q.size() == 0) done = 1;
      end
      check("drain_done", 32'(done), 32'd1);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout");
      $fatal(1, "global timeout");
   end

   initial begin
      req_valid = 0; req_is_dram = 0; req_size_bytes = '0; reset = 1;
      //          use  dram  size      ls     ld      pct     lat dram
      vecs[0] = '{1'b1, 1'b0, 16'd16,   16'd2, 16'd10, 10'd0,    2, 1'b0};
      vecs[1] = '{1'b1, 1'b1, 16'd32,   16'd2, 16'd10, 10'd0,   10, 1'b1};
      vecs[2] = '{1'b1, 1'b0, 16'd8,    16'd0, 16'd10, 10'd0,    1, 1'b0};
      vecs[3] = '{1'b0, 1'b0, 16'd4,    16'd7, 16'd7,  10'd0,    2, 1'b0};
      vecs[4] = '{1'b0, 1'b1, 16'd64,   16'd7, 16'd7,  10'd0,   10, 1'b1};
      vecs[5] = '{1'b1, 1'b0, 16'd16,   16'd3, 16'd5,  10'd1000, 5, 1'b1};
      vecs[6] = '{1'b1, 1'b1, 16'd0,    16'd3, 16'd1,  10'd0,    1, 1'b1};
      vecs[7] = '{1'b1, 1'b1, 16'hFFFF, 16'd3, 16'd4,  10'd0,    4, 1'b1};

      set_cfg(1'b1, 16'd2, 16'd10, 10'd0, 1'b1, 8'd0, 16'd0);
      do_reset();
      @(negedge clk);
      check("reset_req_ready", 32'(req_ready), 32'd1);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_tokens", 32'(dram_tokens_level), 32'd32);
      check("reset_total_reqs", total_reqs, 32'd0);

      for (int v = 0; v < 8; v++) begin
         set_cfg(vecs[v].use_cfg, vecs[v].lat_sram, vecs[v].lat_dram, vecs[v].pct,
                 1'b1, 8'd0, 16'd0);
         do_reset();
         cur_exp_lat = vecs[v].exp_lat;
         send(vecs[v].is_dram, vecs[v].size);
         req_valid = 1'b0;
         wait_drain();
         check("vec_total_reqs", total_reqs, 32'd1);
         check("vec_total_resp", total_resp, 32'd1);
         check("vec_dram_reqs", dram_reqs, 32'(vecs[v].exp_dram));
         check("vec_sram_reqs", sram_reqs, 32'(!vecs[v].exp_dram));
      end

      // 20 back-to-back DRAM 32B: bucket refills as fast as it drains
      set_cfg(1'b1, 16'd2, 16'd10, 10'd0, 1'b1, 8'd4, 16'd32);
      do_reset();
      cur_exp_lat = 10;
      for (int i = 0; i < 20; i++) send(1'b1, 16'd32);
      req_valid = 1'b0;
      wait_drain();
      check("b2b_resp_seen", 32'(resp_seen), 32'd20);
      check("b2b_total_resp", total_resp, 32'd20);
      check("b2b_dram_reqs", dram_reqs, 32'd20);
      check("b2b_token_stalls", dram_token_stall_cycles, 32'd0);

      // 8 DRAM 64B (cost 8), rate 2, cap 8: each later head waits 3 refill cycles
      set_cfg(1'b1, 16'd2, 16'd10, 10'd0, 1'b1, 8'd2, 16'd8);
      do_reset();
      cur_exp_lat = 0;
      for (int i = 0; i < 8; i++) send(1'b1, 16'd64);
      req_valid = 1'b0;
      wait_drain();
      check("cont_resp_seen", 32'(resp_seen), 32'd8);
      check("cont_token_stalls", dram_token_stall_cycles, 32'd21);
      check("cont_events", dram_contention_events, 32'd7);
      check("cont_queue_stalls_nonzero", 32'(stall_cycles > 0), 32'd1);
      check("cont_max_tokens_le_cap", 32'(max_tok <= 16'd8), 32'd1);

      // Same traffic with contention off
      set_cfg(1'b1, 16'd2, 16'd10, 10'd0, 1'b0, 8'd2, 16'd8);
      do_reset();
      cur_exp_lat = 10;
      for (int i = 0; i < 8; i++) send(1'b1, 16'd64);
      req_valid = 1'b0;
      wait_drain();
      check("nocont_resp_seen", 32'(resp_seen), 32'd8);
      check("nocont_token_stalls", dram_token_stall_cycles, 32'd0);
      check("nocont_events", dram_contention_events, 32'd0);
      check("nocont_tokens", 32'(dram_tokens_level), 32'd8);

      // Backpressure: valid held 10 edges, latency 20, depth 4
      set_cfg(1'b1, 16'd20, 16'd10, 10'd0, 1'b1, 8'd0, 16'd0);
      do_reset();
      cur_exp_lat = 20;
      req_valid = 1'b1; req_is_dram = 1'b0; req_size_bytes = 16'd8;
      repeat (10) @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_total_reqs", total_reqs, 32'd4);
      check("bp_stall_cycles", stall_cycles, 32'd6);
      wait_drain();
      check("bp_total_resp", total_resp, 32'd4);

      // Reset with 3 requests in flight
      set_cfg(1'b1, 16'd20, 16'd10, 10'd0, 1'b1, 8'd0, 16'd0);
      do_reset();
      cur_exp_lat = 20;
      for (int i = 0; i < 3; i++) send(1'b0, 16'd16);
      req_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      do_reset();
      @(negedge clk);
      check("rst_total_reqs", total_reqs, 32'd0);
      check("rst_sram_reqs", sram_reqs, 32'd0);
      check("rst_busy_cycles", busy_cycles, 32'd0);
      check("rst_tokens", 32'(dram_tokens_level), 32'd32);
      repeat (30) @(negedge clk);
      check("rst_no_resp", 32'(resp_seen), 32'd0);
      check("rst_total_resp", total_resp, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/memory_latency_injector_contention.md
Name: memory_latency_injector_contention

Overview:
Behavioural memory-timing model for NPU performance simulation. It accepts SRAM/DRAM transfer requests and returns a one-cycle response pulse after a configurable per-class latency. DRAM responses are additionally throttled by a token-bucket bandwidth limiter. Statistics counters are exported for perf analysis.

Parameters:
SIZE_WIDTH, 16, width of request/response byte-size fields
LATENCY_SRAM_CYCLES, 2, default SRAM latency (used when cfg_use_cfg_latencies=0)
LATENCY_DRAM_CYCLES, 10, default DRAM latency
PIPELINE_RESP, 0, 1 = add one output register stage (+1 cycle latency)
QUEUE_DEPTH, 4, outstanding-request FIFO depth (power of 2)
EXTRA_LATENCY_MAX, 0, max pseudo-random extra cycles added per request
LATENCY_DIST_MODE, 0, 0 = uniform extra in [0,EXTRA_LATENCY_MAX]; 1 = fixed EXTRA_LATENCY_MAX
DRAM_TOKENS_PER_CYCLE, 4, refill rate used when cfg_tokens_per_cycle=0
DRAM_TOKEN_CAPACITY, 32, bucket capacity used when cfg_token_capacity=0; reset fill level
SIZE_TO_TOKENS_SHIFT, 3, token cost = size_bytes >> shift

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
req_valid  in  1  request strobe
req_is_dram  in  1  1 = DRAM request
req_size_bytes  in  SIZE_WIDTH  transfer size
req_ready  out  1  queue not full
resp_valid  out  1  one-cycle response pulse
resp_size_bytes  out  SIZE_WIDTH  size of the completing request
cfg_latency_sram  in  16  runtime SRAM latency
cfg_latency_dram  in  16  runtime DRAM latency
cfg_dram_hit_milli_pct  in  10  per-mille probability an SRAM request is reclassified as DRAM
cfg_use_cfg_latencies  in  1  1 = use cfg latencies, 0 = parameters
cfg_enable_contention  in  1  1 = token bucket active
cfg_tokens_per_cycle  in  8  refill rate; 0 selects parameter
cfg_token_capacity  in  16  capacity; 0 selects parameter
total_reqs, total_resp, sram_reqs, dram_reqs, stall_cycles, busy_cycles  out  32 each  counters
busy  out  1  queue non-empty
dram_tokens_level  out  16  current bucket fill
dram_token_stall_cycles  out  32  cycles the head DRAM response was blocked by tokens
dram_contention_events  out  32  number of DRAM responses that were blocked at least one cycle

Behaviour:
- Reset is synchronous on clk, active-high. It clears the FIFO, all counters and resp_valid, and reloads the LFSR seed. Tokens are set to the effective capacity. Reset mid-operation drops all in-flight requests.
- Accept: the request is accepted when req_valid && req_ready; req_ready = !full. The entry stores size, class and latency L = base + extra.
- Classification: if req_is_dram=0 and cfg_dram_hit_milli_pct>0, a 16-bit LFSR value mod 1000 < pct reclassifies the request as DRAM. pct>=1000 means always DRAM.
- Each entry's countdown decrements every cycle and saturates at 0. Effective L is min 1.
- Response: a request accepted at edge T pulses resp_valid in the cycle after edge T+L (plus 1 if PIPELINE_RESP).
- Ordering: responses are in-order, one per cycle. A non-head entry that expires waits behind the head.
- Token bucket (cfg_enable_contention=1):
  - cost = max(1, size>>SHIFT), clamped to capacity.
  - An expired DRAM head completes only if tokens >= cost.
  - Next tokens = min(cap, tokens - (granted ? cost : 0) + rate).
  - Each blocked cycle increments dram_token_stall_cycles. The first blocked cycle of an entry increments dram_contention_events.
  - SRAM entries never use tokens.
- With contention disabled, tokens stay at capacity and never block.
- Counters (wrap at 2^32):
  - total_reqs, sram_reqs and dram_reqs count accepts; dram_reqs uses the post-reclassification class.
  - total_resp counts resp_valid pulses.
  - stall_cycles counts req_valid && !req_ready cycles.
  - busy_cycles counts busy cycles.
- Simultaneous accept and response while full: req_ready is based on the registered count, so there is no same-cycle bypass.

Decomposition:
- Package mli_pkg holds the FIFO entry struct (size, is_dram, countdown, blocked flag), LFSR polynomial constant and counter width.
- Optional sub-module dram_token_bucket (refill/consume/saturate, grant output).

Test Plan:
- Single SRAM request, size 16, cfg_latency_sram=2, cfg_use_cfg_latencies=1 -> resp_valid 2 cycles after accept, resp_size=16, total_reqs=total_resp=1, sram_reqs=1.
- 20 back-to-back DRAM 32B requests, latency 10, rate 4, capacity 32 -> 20 responses, dram_token_stall_cycles=0, dram_reqs=20.
- 8 DRAM 64B requests (8 tokens), rate 2, capacity 8, queue filled -> stalls>0, contention_events>0, dram_tokens_level never exceeds 8, all 8 respond.
- Keep req_valid high with response latency 20, depth 4 -> req_ready drops after 4 accepts, stall_cycles increments each blocked cycle.
- Same as the 64B stall test but cfg_enable_contention=0 -> dram_token_stall_cycles=0 and tokens=capacity.
- Assert reset with 3 requests in flight -> no further resp_valid, all counters 0, dram_tokens_level=capacity.
